// File: rtl/joystick_zone_tracker.sv
// joystick_zone_tracker: box-car averages joystick samples, classifies them into hysteresis zones
// with one-hot LEDs, and flags a stale joystick when samples stop arriving.
module joystick_zone_tracker #(
    parameter int WIDTH     = 10,
    parameter int NUM_ZONES = 5,
    parameter int AVG_LOG2  = 2,
    parameter int HYST      = 8,
    parameter int TIMEOUT   = 1000000,
    parameter bit INVERT    = 1
) (
    input  logic                         clk50M,
    input  logic                         rst,
    input  logic                         sample_valid,
    input  logic [WIDTH-1:0]             sample,
    output logic [WIDTH-1:0]             avg,
    output logic                         avg_valid,
    output logic [$clog2(NUM_ZONES)-1:0] zone,
    output logic                         zone_changed,
    output logic [NUM_ZONES-1:0]         leds,
    output logic                         stale
);
    localparam int ZW = $clog2(NUM_ZONES);
    localparam int AW = WIDTH + AVG_LOG2;
    localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    function automatic longint bnd(input int k);
        return (longint'(k) << WIDTH) / NUM_ZONES;
    endfunction

    function automatic logic [ZW-1:0] rawz(input logic [WIDTH-1:0] a);
        logic [ZW-1:0] r;
        r = '0;
        for (int k = 1; k < 16; k++)
            if (k < NUM_ZONES && longint'(a) >= bnd(k)) r = ZW'(k);
        return r;
    endfunction

    // Moving to a neighbouring zone needs HYST counts of penetration past its edge.
    function automatic logic [ZW-1:0] tgt(input logic [WIDTH-1:0] a, input logic [ZW-1:0] z);
        logic [ZW-1:0] r;
        longint v;
        r = rawz(a);
        v = longint'(a);
        return r > z ? (v >= bnd(int'(r)) + HYST ? r : r - 1'b1) :
               r < z ? (v <= bnd(int'(r) + 1) - 1 - HYST ? r : r + 1'b1) : z;
    endfunction

    logic [AW-1:0] acc, sum;
    logic [CW-1:0] cnt;
    logic [TW-1:0] wd;
    logic [ZW-1:0] nz;
    logic          last;

    always_comb begin
        sum  = acc + AW'(sample);
        last = (AVG_LOG2 == 0) || (cnt == CW'((1 << AVG_LOG2) - 1));
        nz   = tgt(avg, zone);
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= sample_valid && last;
            if (sample_valid) begin
                acc <= last ? '0 : sum;
                cnt <= last ? '0 : CW'(cnt + 1'b1);
                if (last) avg <= WIDTH'(sum >> AVG_LOG2);
            end
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            zone         <= ZW'(NUM_ZONES / 2);
            zone_changed <= 1'b0;
        end else begin
            zone_changed <= avg_valid && nz != zone;
            if (avg_valid) zone <= nz;
        end
    end

    // Stale clears on a completed average, which also outranks a simultaneous timeout.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            wd    <= '0;
            stale <= 1'b1;
        end else begin
            wd    <= sample_valid ? '0 : wd == TW'(TIMEOUT) ? wd : TW'(wd + 1'b1);
            stale <= avg_valid ? 1'b0 : wd == TW'(TIMEOUT) ? 1'b1 : stale;
        end
    end

    assign leds = NUM_ZONES'(1) << (INVERT ? NUM_ZONES - 1 - int'(zone) : int'(zone));
endmodule

// File: tb/tb_joystick_zone_tracker.sv
// tb_joystick_zone_tracker: scoreboard bench with a behavioural reference model of averaging,
// hysteresis zoning and the stale watchdog, driven by directed and randomized groups.
module tb_joystick_zone_tracker;
    localparam int W = 10;
    localparam int N = 5;
    localparam int A = 2;
    localparam int H = 8;
    localparam int T = 20;

    logic         clk50M = 0;
    logic         rst = 1;
    logic         sample_valid = 0;
    logic [W-1:0] sample = '0;
    logic [W-1:0] avg;
    logic         avg_valid;
    logic [2:0]   zone;
    logic         zone_changed;
    logic [N-1:0] leds;
    logic         stale;

    int checks = 0;
    int errors = 0;

    typedef struct {int a; int z; bit c;} exp_t;
    exp_t q[$];

    always #10 clk50M = ~clk50M;

    joystick_zone_tracker #(.WIDTH(W), .NUM_ZONES(N), .AVG_LOG2(A), .HYST(H), .TIMEOUT(T), .INVERT(1)) dut (
        .clk50M(clk50M), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .avg(avg), .avg_valid(avg_valid), .zone(zone), .zone_changed(zone_changed),
        .leds(leds), .stale(stale)
    );

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, req);
        end
    endtask

    function automatic int bnd(input int k);
        return (k * (1 << W)) / N;
    endfunction

    function automatic int next_zone(input int a, input int z);
        int r = 0;
        for (int k = 1; k < N; k++) if (a >= bnd(k)) r = k;
        if (r > z && a < bnd(r) + H) return r - 1;
        if (r < z && a > bnd(r + 1) - 1 - H) return r + 1;
        return r;
    endfunction

    int grp[$];
    int mz = N / 2;
    int since = 0;
    bit av_d = 0;
    bit exp_stale = 1;

    always @(posedge clk50M) begin : model
        int s;
        int nzm;
        if (rst) begin
            grp.delete();
            q.delete();
            mz = N / 2;
            since = 0;
            av_d = 0;
            exp_stale = 1;
        end else begin
            exp_stale = av_d ? 0 : (since == T) ? 1 : exp_stale;
            av_d = 0;
            since = sample_valid ? 0 : (since < T ? since + 1 : T);
            if (sample_valid) begin
                grp.push_back(int'(sample));
                if (grp.size() == (1 << A)) begin
                    s = 0;
                    foreach (grp[i]) s += grp[i];
                    s = s / (1 << A);
                    nzm = next_zone(s, mz);
                    q.push_back('{s, nzm, nzm != mz});
                    mz = nzm;
                    av_d = 1;
                    grp.delete();
                end
            end
        end
    end

    bit   pend = 0;
    exp_t pe;

    always @(negedge clk50M) begin
        if (rst) pend = 0;
        else begin
            chk("stale", stale, exp_stale);
            if (pend) begin
                chk("zone", zone, pe.z);
                chk("zone_changed", zone_changed, pe.c);
                chk("leds", leds, 1 << (N - 1 - pe.z));
                pend = 0;
            end else chk("zone_changed_idle", zone_changed, 0);
            if (avg_valid) begin
                if (q.size() == 0) chk("avg_valid_unexpected", avg_valid, 0);
                else begin
                    pe = q.pop_front();
                    chk("avg", avg, pe.a);
                    pend = 1;
                end
            end
        end
    end

    task automatic tick(input bit v, input int s);
        @(posedge clk50M);
        #1;
        sample_valid = v;
        sample = W'(s);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0);
    endtask

    task automatic send4(input int v);
        repeat (4) tick(1, v);
        tick(0, 0);
    endtask

    task automatic rst_pulse();
        @(posedge clk50M);
        #1;
        rst = 1;
        sample_valid = 0;
        @(posedge clk50M);
        #1;
        rst = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int v;
        idle(3);
        rst = 0;
        @(negedge clk50M);
        chk("reset_zone", zone, 2);
        chk("reset_leds", leds, 5'b00100);
        chk("reset_stale", stale, 1);
        chk("reset_avg", avg, 0);
        chk("reset_avg_valid", avg_valid, 0);
        send4(1023);
        idle(3);
        rst_pulse();
        send4(620);
        send4(622);
        send4(606);
        send4(605);
        tick(1, 0); tick(1, 0); tick(1, 0); tick(1, 1023); tick(0, 0);
        send4(1023);
        send4(0);
        idle(30);
        send4(500);
        idle(25);
        tick(1, 900); tick(1, 900);
        rst_pulse();
        send4(100);
        idle(3);
        repeat (150) begin
            c = ($urandom_range(0, 1) == 1) ? bnd($urandom_range(1, N - 1)) + $urandom_range(0, 30) - 15
                                            : $urandom_range(0, (1 << W) - 1);
            if ($urandom_range(0, 9) == 0) idle($urandom_range(15, 30));
            repeat (4) begin
                v = c + $urandom_range(0, 6) - 3;
                v = v < 0 ? 0 : v > (1 << W) - 1 ? (1 << W) - 1 : v;
                tick(1, v);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        idle(6);
        chk("queue_drained", q.size() + int'(pend), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/joystick_zone_tracker.md
# joystick_zone_tracker

Parametrised successor to the fixed five-LED joystick threshold decoder. It takes the stream of axis samples from the SPI joystick reader (`valid` strobe plus value) and box-car averages every 2^AVG_LOG2 samples. It then classifies the average into NUM_ZONES equal-width zones with hysteresis and drives the one-hot zone LEDs. It also flags a stale joystick when samples stop arriving. It sits between the joystick SPI reader and the paddle/LED logic.

## Interface
- WIDTH, 10: sample and average width in bits.
- NUM_ZONES, 5: number of zones, 2..16.
- AVG_LOG2, 2: log2 of samples per average, 0..4.
- HYST, 8: hysteresis margin in counts. Must be less than half of one zone width.
- TIMEOUT, 1000000: clk50M cycles without `sample_valid` before `stale` asserts.
- INVERT, 1: 1 maps zone z to `leds[NUM_ZONES-1-z]`, so the highest zone lights `leds[0]`. 0 maps zone z to `leds[z]`.
- clk50M  input  1  system clock. One clock; every register is clocked on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe: `sample` is valid this cycle.
- sample  input  WIDTH  raw axis value from the SPI reader.
- avg  output  WIDTH  last completed average.
- avg_valid  output  1  one-cycle pulse when `avg` updates.
- zone  output  clog2(NUM_ZONES)  current hysteresis-filtered zone.
- zone_changed  output  1  one-cycle pulse when `zone` changes.
- leds  output  NUM_ZONES  one-hot zone indicator.
- stale  output  1  no sample received for TIMEOUT cycles.

## Operation
- Boundaries are computed at elaboration: B_k = (k * 2^WIDTH) / NUM_ZONES, integer division.
  - B_0 = 0 and B_N = 2^WIDTH.
  - Zone r covers B_r <= value < B_{r+1}.
- Accumulator:
  - Width is WIDTH+AVG_LOG2; sample counter is AVG_LOG2 bits.
  - Each `sample_valid` adds `sample` to the accumulator and increments the counter.
  - On the 2^AVG_LOG2-th sample: `avg` <= (acc + sample) >> AVG_LOG2 (truncating), `avg_valid` pulses, and acc and the counter clear.
  - With AVG_LOG2 = 0, every sample produces an average.
- Zone update runs on the cycle when `avg_valid` = 1, using `avg`. Let r be the raw zone of `avg` and z the current zone.
  - r == z: no change.
  - r > z: if avg >= B_r + HYST, the target is r; otherwise the target is r-1.
  - r < z: if avg <= B_{r+1} - 1 - HYST, the target is r; otherwise the target is r+1.
  - If target != z: `zone` <= target and `zone_changed` pulses.
  - Multi-zone jumps happen in a single update.
- `leds` is always exactly one-hot from `zone`, mapped per INVERT.
- Stale watchdog:
  - The counter clears on `sample_valid` and otherwise increments, saturating at TIMEOUT.
  - `stale` <= 1 when the counter equals TIMEOUT.
  - `stale` <= 0 on `avg_valid`; clear wins if both happen in the same cycle.
  - `zone` holds while `stale` = 1.
- Reset values:
  - acc = 0, sample count = 0, watchdog = 0.
  - `avg` = 0, `avg_valid` = 0, `zone_changed` = 0.
  - `zone` = NUM_ZONES/2 (centre, stick at rest); `leds` = matching one-hot.
  - `stale` = 1 until the first average completes.
- Reset mid-accumulation discards the partial sum.
- `sample_valid` is ignored while `rst` = 1.

## Timing
- `sample_valid` may assert on every cycle; there is no backpressure.
- Last sample of a group accepted at cycle N: `avg`/`avg_valid` at N+1; `zone`/`zone_changed`/`leds` at N+2.
- Back-to-back groups are fully pipelined. A new group's first sample at N+1 does not disturb the N+2 zone update.
- Outputs are registered; there is no combinational path from inputs to outputs.
- With defaults, the boundaries are 204, 409, 614, 819.

## Test plan
- Reset, no stimulus -> `zone` = 2, `leds` = 5'b00100, `stale` = 1, `avg` = 0, `avg_valid` = 0.
- Four samples of 10'h3FF on consecutive cycles -> `avg` = 1023 and `avg_valid` one cycle after the last sample. One cycle later: `zone` = 4, one `zone_changed` pulse, `leds` = 5'b00001, `stale` = 0.
- Upward hysteresis from zone 2 -> group of 620s gives `avg` = 620 with no change, since 620 < 622. Group of 622s gives `zone` = 3.
- Downward hysteresis from zone 3 -> group of 606s gives no change. Group of 605s gives `zone` = 2.
- Averaging and jump -> samples 0, 0, 0, 1023 from zone 2 give `avg` = 255 and `zone` = 1. From zone 4, a group of 0s gives a direct jump to `zone` = 0 with a single `zone_changed` pulse.
- Watchdog/reset -> with TIMEOUT = 20, `stale` rises 20 idle cycles after the last sample and `zone` holds; the next completed average clears it. Sending two samples, pulsing `rst`, then four samples of 100 gives `avg` = 100, with no contribution from the pre-reset samples.
